// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode-stage operand front end: stall bus layout and branch opcodes.
package id_operand_stage_pkg;

  localparam int STALL_W_DFLT = 6;
  localparam int ID_STALL_BIT = 1;

  typedef logic [STALL_W_DFLT-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// One operand's forwarding select: lowest-index matching channel wins, register 0 reads zero,
// and the winner's load-in-flight flag is reported for the interlock.
module id_fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [RA_W-1:0]         i_raddr,
  input  logic [DATA_W-1:0]       i_rf_rdata,
  input  logic [NUM_FWD-1:0]      i_fwd_we,
  input  logic [NUM_FWD*RA_W-1:0] i_fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_wdata,
  input  logic [NUM_FWD-1:0]      i_fwd_is_load,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_load
);

  logic [DATA_W-1:0] w_data;
  logic              w_load;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    w_data = i_rf_rdata;
    w_load = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_we[i] && (i_fwd_waddr[i*RA_W +: RA_W] == i_raddr)) begin
        w_data = i_fwd_wdata[i*DATA_W +: DATA_W];
        w_load = i_fwd_is_load[i];
      end
    end
    if (i_raddr == '0) begin
      w_data = '0;
      w_load = 1'b0;
    end
  end

  assign o_data = w_data;
  assign o_load = w_load;

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage front end: IF/ID register, held-instruction buffer, operand forwarding,
// load-use interlock and branch/jump resolution.
//   state | meaning
//   LIVE  | instruction comes straight from the SRAM read data
//   HELD  | ID stalled; instruction replayed from the hold register
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 5,
  parameter int NUM_FWD = 3,
  parameter int STALL_W = STALL_W_DFLT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [STALL_W-1:0]        i_stall,
  input  logic                      i_if_valid,
  input  logic [DATA_W-1:0]         i_if_pc,
  input  logic [31:0]               i_inst_sram_rdata,
  output logic [RA_W-1:0]           o_rf_raddr1,
  output logic [RA_W-1:0]           o_rf_raddr2,
  input  logic [DATA_W-1:0]         i_rf_rdata1,
  input  logic [DATA_W-1:0]         i_rf_rdata2,
  input  logic [NUM_FWD-1:0]        i_fwd_we,
  input  logic [NUM_FWD*RA_W-1:0]   i_fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_wdata,
  input  logic [NUM_FWD-1:0]        i_fwd_is_load,
  output logic                      o_id_valid,
  output logic [DATA_W-1:0]         o_id_pc,
  output logic [31:0]               o_id_inst,
  output logic [DATA_W-1:0]         o_id_src1,
  output logic [DATA_W-1:0]         o_id_src2,
  output logic                      o_stallreq,
  output logic                      o_br_taken,
  output logic [DATA_W-1:0]         o_br_target
);

  localparam logic [0:0] S_LIVE = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;

  logic [0:0]        r_state;
  logic              r_id_valid;
  logic [DATA_W-1:0] r_id_pc;
  logic [31:0]       r_hold;

  logic              w_id_stop;
  logic [31:0]       w_inst_raw;
  logic [31:0]       w_inst;
  logic [RA_W-1:0]   w_rs;
  logic [RA_W-1:0]   w_rt;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;
  logic              w_load1;
  logic              w_load2;
  logic              w_stallreq;
  logic [5:0]        w_op;
  logic [DATA_W-1:0] w_pc4;
  logic [DATA_W-1:0] w_br_off;
  logic [DATA_W-1:0] w_target;
  logic              w_cond;
  logic              w_taken;
  logic              w_unused_stall;

  assign w_id_stop = (i_stall[ID_STALL_BIT] == STOP);
  assign w_unused_stall = ^{i_stall[STALL_W-1:ID_STALL_BIT+1], i_stall[ID_STALL_BIT-1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
    end else if (!w_id_stop) begin
      r_id_valid <= i_if_valid;
      r_id_pc    <= i_if_pc;
    end
  end

  // SRAM data is only presented for one cycle, so the first stalled cycle must latch it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LIVE;
      r_hold  <= '0;
    end else if (r_state == S_LIVE) begin
      if (w_id_stop) begin
        r_hold  <= i_inst_sram_rdata;
        r_state <= S_HELD;
      end
    end else begin
      if (!w_id_stop) begin
        r_hold  <= '0;
        r_state <= S_LIVE;
      end
    end
  end

  assign w_inst_raw = (r_state == S_HELD) ? r_hold : i_inst_sram_rdata;
  assign w_inst     = r_id_valid ? w_inst_raw : 32'h0;
  assign w_rs       = w_inst[25:21];
  assign w_rt       = w_inst[20:16];

  id_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rs (
    .i_raddr       (w_rs),
    .i_rf_rdata    (i_rf_rdata1),
    .i_fwd_we      (i_fwd_we),
    .i_fwd_waddr   (i_fwd_waddr),
    .i_fwd_wdata   (i_fwd_wdata),
    .i_fwd_is_load (i_fwd_is_load),
    .o_data        (w_src1),
    .o_load        (w_load1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd_rt (
    .i_raddr       (w_rt),
    .i_rf_rdata    (i_rf_rdata2),
    .i_fwd_we      (i_fwd_we),
    .i_fwd_waddr   (i_fwd_waddr),
    .i_fwd_wdata   (i_fwd_wdata),
    .i_fwd_is_load (i_fwd_is_load),
    .o_data        (w_src2),
    .o_load        (w_load2)
  );

  assign w_stallreq = r_id_valid && (w_load1 || w_load2);

  assign w_op     = w_inst[31:26];
  assign w_pc4    = r_id_pc + DATA_W'(4);
  assign w_br_off = {{(DATA_W-18){w_inst[15]}}, w_inst[15:0], 2'b00};

  always_comb begin
    w_cond = 1'b0;
    case (w_op)
      OP_BEQ:  w_cond = (w_src1 == w_src2);
      OP_BNE:  w_cond = (w_src1 != w_src2);
      OP_BLEZ: w_cond = w_src1[DATA_W-1] || (w_src1 == '0);
      OP_BGTZ: w_cond = !w_src1[DATA_W-1] && (w_src1 != '0);
      OP_J,
      OP_JAL:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_target = is_jump_op(w_op) ? {w_pc4[DATA_W-1:28], w_inst[25:0], 2'b00}
                                     : (w_pc4 + w_br_off);
  assign w_taken  = r_id_valid && !w_stallreq && w_cond;

  assign o_rf_raddr1 = w_rs;
  assign o_rf_raddr2 = w_rt;
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_valid ? r_id_pc : '0;
  assign o_id_inst   = w_inst;
  assign o_id_src1   = w_src1;
  assign o_id_src2   = w_src2;
  assign o_stallreq  = w_stallreq;
  assign o_br_taken  = w_taken;
  assign o_br_target = w_taken ? w_target : '0;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus a randomized run
// against a behavioural model of the decode front end.
module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int NF = 3;
  localparam int SW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [SW-1:0]  stall;
  logic           if_valid;
  logic [DW-1:0]  if_pc;
  logic [31:0]    rdata;
  logic [RW-1:0]  raddr1, raddr2;
  logic [DW-1:0]  rdata1, rdata2;
  logic [NF-1:0]  fwd_we, fwd_is_load;
  logic [NF*RW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic           id_valid, stallreq, br_taken;
  logic [DW-1:0]  id_pc, id_src1, id_src2, br_target;
  logic [31:0]    id_inst;

  logic [DW-1:0]  regs [32];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_hold;

  logic [31:0] e_inst, e_pc, e_src1, e_src2, e_target;
  logic [4:0]  e_rs, e_rt;
  bit          e_stall, e_taken;

  id_operand_stage #(.DATA_W(DW), .RA_W(RW), .NUM_FWD(NF), .STALL_W(SW)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_if_valid        (if_valid),
    .i_if_pc           (if_pc),
    .i_inst_sram_rdata (rdata),
    .o_rf_raddr1       (raddr1),
    .o_rf_raddr2       (raddr2),
    .i_rf_rdata1       (rdata1),
    .i_rf_rdata2       (rdata2),
    .i_fwd_we          (fwd_we),
    .i_fwd_waddr       (fwd_waddr),
    .i_fwd_wdata       (fwd_wdata),
    .i_fwd_is_load     (fwd_is_load),
    .o_id_valid        (id_valid),
    .o_id_pc           (id_pc),
    .o_id_inst         (id_inst),
    .o_id_src1         (id_src1),
    .o_id_src2         (id_src2),
    .o_stallreq        (stallreq),
    .o_br_taken        (br_taken),
    .o_br_target       (br_target)
  );

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    if (rst) begin
      m_valid = 0; m_pc = 0; m_held = 0; m_hold = 0;
    end else if (stall[1]) begin
      if (!m_held) begin
        m_held = 1; m_hold = rdata;
      end
    end else begin
      m_held = 0; m_hold = 0; m_valid = if_valid; m_pc = if_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int ch, input bit we, input logic [4:0] a,
                         input logic [31:0] d, input bit ld);
    fwd_we[ch] = we;
    fwd_waddr[ch*RW +: RW] = a;
    fwd_wdata[ch*DW +: DW] = d;
    fwd_is_load[ch] = ld;
  endtask

  task automatic clear_fwd();
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0;
  endtask

  function automatic void lookup(input logic [4:0] a, output logic [31:0] d, output bit ld);
    bit found = 0;
    d = regs[a];
    ld = 0;
    for (int i = 0; i < NF; i++) begin
      if (!found && fwd_we[i] && fwd_waddr[i*RW +: RW] == a) begin
        found = 1;
        d = fwd_wdata[i*DW +: DW];
        ld = fwd_is_load[i];
      end
    end
    if (a == 0) begin
      d = 0;
      ld = 0;
    end
  endfunction

  task automatic model_eval();
    bit ld1, ld2, c;
    logic [5:0]  op;
    logic [31:0] seq;
    e_inst = m_valid ? (m_held ? m_hold : rdata) : 32'h0;
    e_pc   = m_valid ? m_pc : 32'h0;
    e_rs   = e_inst[25:21];
    e_rt   = e_inst[20:16];
    lookup(e_rs, e_src1, ld1);
    lookup(e_rt, e_src2, ld2);
    e_stall = m_valid && (ld1 || ld2);
    op  = e_inst[31:26];
    seq = m_pc + 32'd4;
    case (op)
      6'h04: c = (e_src1 == e_src2);
      6'h05: c = (e_src1 != e_src2);
      6'h06: c = ($signed(e_src1) <= 0);
      6'h07: c = ($signed(e_src1) > 0);
      6'h02, 6'h03: c = 1;
      default: c = 0;
    endcase
    e_taken = m_valid && !e_stall && c;
    if (!e_taken) e_target = 0;
    else if (op == 6'h02 || op == 6'h03) e_target = {seq[31:28], e_inst[25:0], 2'b00};
    else e_target = seq + {{14{e_inst[15]}}, e_inst[15:0], 2'b00};
  endtask

  task automatic test_reset();
    clear_fwd();
    stall = 0; if_valid = 1; if_pc = 32'h200;
    tick();
    rdata = {6'h00, 5'd1, 5'd2, 16'h0};
    set_fwd(0, 1, 5'd1, 32'hDEAD, 1);
    stall = 6'b000010;
    tick();
    rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (id_inst !== 32'h0022_0000) begin n_err++; $display("FAIL rst_pre_hold: id_inst=%h expected %h", id_inst, 32'h0022_0000); end
    rst = 1;
    repeat (3) tick();
    n_cmp++;
    if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: id_valid=%b expected 0", id_valid); end
    n_cmp++;
    if (id_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: id_inst=%h expected 0", id_inst); end
    n_cmp++;
    if (stallreq !== 1'b0 || br_taken !== 1'b0 || id_pc !== 32'h0) begin
      n_err++; $display("FAIL rst_outs: stallreq=%b br_taken=%b id_pc=%h expected 0/0/0", stallreq, br_taken, id_pc);
    end
    rst = 0; clear_fwd(); stall = 0; if_valid = 1; if_pc = 32'h300;
    tick();
    rdata = 32'h2408_1234;
    #1;
    n_cmp++;
    if (id_inst !== 32'h2408_1234 || id_pc !== 32'h300) begin
      n_err++; $display("FAIL rst_live: id_inst=%h id_pc=%h expected %h %h", id_inst, id_pc, 32'h2408_1234, 32'h300);
    end
  endtask

  task automatic test_hold();
    clear_fwd();
    stall = 0; if_valid = 1; if_pc = 32'hBFC0_0000;
    tick();
    rdata = 32'h3402_0005; stall = 6'b000010; if_pc = 32'hBFC0_0004;
    #1;
    n_cmp++;
    if (id_inst !== 32'h3402_0005 || id_pc !== 32'hBFC0_0000) begin
      n_err++; $display("FAIL hold_first: id_inst=%h id_pc=%h expected 34020005 bfc00000", id_inst, id_pc);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      rdata = $urandom;
      #1;
      n_cmp++;
      if (id_inst !== 32'h3402_0005 || id_pc !== 32'hBFC0_0000) begin
        n_err++; $display("FAIL hold_stalled: id_inst=%h id_pc=%h expected 34020005 bfc00000", id_inst, id_pc);
      end
    end
    tick();
    stall = 0; rdata = $urandom;
    #1;
    n_cmp++;
    if (id_inst !== 32'h3402_0005) begin n_err++; $display("FAIL hold_release: id_inst=%h expected 34020005", id_inst); end
    tick();
    rdata = 32'h2403_0007;
    #1;
    n_cmp++;
    if (id_inst !== 32'h2403_0007 || id_pc !== 32'hBFC0_0004) begin
      n_err++; $display("FAIL hold_next: id_inst=%h id_pc=%h expected 24030007 bfc00004", id_inst, id_pc);
    end
  endtask

  task automatic test_priority();
    clear_fwd();
    stall = 0; if_valid = 1; if_pc = 32'h400;
    tick();
    rdata = {6'h00, 5'd2, 5'd0, 16'h0020};
    set_fwd(0, 1, 5'd2, 32'h11, 0);
    set_fwd(2, 1, 5'd2, 32'h22, 0);
    #1;
    n_cmp++;
    if (id_src1 !== 32'h11) begin n_err++; $display("FAIL prio_ch0: id_src1=%h expected 11", id_src1); end
    set_fwd(0, 0, 5'd2, 32'h11, 0);
    #1;
    n_cmp++;
    if (id_src1 !== 32'h22) begin n_err++; $display("FAIL prio_ch2: id_src1=%h expected 22", id_src1); end
    set_fwd(2, 0, 5'd0, 32'h0, 0);
    #1;
    n_cmp++;
    if (id_src1 !== regs[2]) begin n_err++; $display("FAIL prio_rf: id_src1=%h expected %h", id_src1, regs[2]); end
    rdata = {6'h00, 5'd0, 5'd0, 16'h0020};
    set_fwd(0, 1, 5'd0, 32'hFF, 1);
    #1;
    n_cmp++;
    if (id_src1 !== 32'h0 || stallreq !== 1'b0) begin
      n_err++; $display("FAIL prio_zero: id_src1=%h stallreq=%b expected 0/0", id_src1, stallreq);
    end
  endtask

  task automatic test_load_use();
    clear_fwd();
    stall = 0; if_valid = 1; if_pc = 32'h500;
    tick();
    rdata = {6'h04, 5'd1, 5'd3, 16'h0010};
    set_fwd(0, 1, 5'd3, regs[1], 1);
    #1;
    n_cmp++;
    if (stallreq !== 1'b1 || br_taken !== 1'b0) begin
      n_err++; $display("FAIL lu_stall: stallreq=%b br_taken=%b expected 1/0", stallreq, br_taken);
    end
    set_fwd(0, 1, 5'd3, regs[1], 0);
    set_fwd(1, 1, 5'd3, 32'h5555, 1);
    #1;
    n_cmp++;
    if (stallreq !== 1'b0 || br_taken !== 1'b1 || br_target !== 32'h544) begin
      n_err++; $display("FAIL lu_masked: stallreq=%b br_taken=%b br_target=%h expected 0/1/544", stallreq, br_taken, br_target);
    end
  endtask

  task automatic test_branch();
    clear_fwd();
    stall = 0; if_valid = 1; if_pc = 32'h100;
    tick();
    rdata = {6'h04, 5'd5, 5'd5, 16'hFFFF};
    if_pc = 32'hBFC0_0010;
    #1;
    n_cmp++;
    if (br_taken !== 1'b1 || br_target !== 32'h100) begin
      n_err++; $display("FAIL br_beq: br_taken=%b br_target=%h expected 1/100", br_taken, br_target);
    end
    rdata = {6'h05, 5'd5, 5'd5, 16'hFFFF};
    #1;
    n_cmp++;
    if (br_taken !== 1'b0 || br_target !== 32'h0) begin
      n_err++; $display("FAIL br_bne: br_taken=%b br_target=%h expected 0/0", br_taken, br_target);
    end
    tick();
    rdata = {6'h02, 26'h40};
    #1;
    n_cmp++;
    if (br_taken !== 1'b1 || br_target !== 32'hB000_0100) begin
      n_err++; $display("FAIL br_j: br_taken=%b br_target=%h expected 1/b0000100", br_taken, br_target);
    end
  endtask

  task automatic test_bubble();
    clear_fwd();
    stall = 0; if_valid = 0; if_pc = 32'h600;
    tick();
    rdata = {6'h04, 5'd0, 5'd0, 16'h0004};
    set_fwd(0, 1, 5'd0, 32'h1, 1);
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
      n_err++; $display("FAIL bubble_id: id_valid=%b id_inst=%h id_pc=%h expected 0/0/0", id_valid, id_inst, id_pc);
    end
    n_cmp++;
    if (stallreq !== 1'b0 || br_taken !== 1'b0 || br_target !== 32'h0) begin
      n_err++; $display("FAIL bubble_ctl: stallreq=%b br_taken=%b br_target=%h expected 0/0/0", stallreq, br_taken, br_target);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h03; ops[3] = 6'h04;
    ops[4] = 6'h05; ops[5] = 6'h06; ops[6] = 6'h07; ops[7] = 6'h0D;
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 60) == 0);
      stall    = 6'($urandom) & 6'b111101;
      stall[1] = ($urandom_range(0, 9) < 4);
      if_valid = ($urandom_range(0, 9) < 8);
      if_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rdata    = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      for (int c = 0; c < NF; c++)
        set_fwd(c, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, ($urandom_range(0, 9) < 3));
      #1;
      model_eval();
      n_cmp++;
      if ({id_valid, id_pc, id_inst, raddr1, raddr2} !== {m_valid, e_pc, e_inst, e_rs, e_rt}) begin
        n_err++;
        $display("FAIL rnd_id[%0d]: got v=%b pc=%h inst=%h ra=%0d/%0d expected v=%b pc=%h inst=%h ra=%0d/%0d",
                 n, id_valid, id_pc, id_inst, raddr1, raddr2, m_valid, e_pc, e_inst, e_rs, e_rt);
      end
      n_cmp++;
      if ({id_src1, id_src2, stallreq, br_taken, br_target} !== {e_src1, e_src2, e_stall, e_taken, e_target}) begin
        n_err++;
        $display("FAIL rnd_ex[%0d]: got s1=%h s2=%h stl=%b tk=%b tgt=%h expected s1=%h s2=%h stl=%b tk=%b tgt=%h",
                 n, id_src1, id_src2, stallreq, br_taken, br_target, e_src1, e_src2, e_stall, e_taken, e_target);
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[5] = 32'h0000_0005;
    rst = 1; stall = 0; if_valid = 0; if_pc = 0; rdata = 0;
    clear_fwd();
    m_valid = 0; m_pc = 0; m_held = 0; m_hold = 0;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_hold();
    test_priority();
    test_load_use();
    test_branch();
    test_bubble();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
